conv_window_scheduler: RTL and testbench

Upstream sequencer for one convolution PE. Walks every output position of an IMG_H x IMG_W frame and hands the PE the window origin. Pulses the PE start, tracks the PE done level through its clear/calc phases, then emits one write strobe per output position to the result buffer under valid/ready backpressure.

---
 rtl/conv_pkg.sv | 21 ++
 rtl/conv_window_scheduler_pos_counter.sv | 73 +++++++
 rtl/conv_window_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_conv_window_scheduler.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants for the convolution window scheduler: FSM state codes,
// the index width used toward the PE control, and the output-dimension helper.
package conv_pkg;

    // Width of every position/index bus exchanged with the PE side.
    localparam int IDX_W = 32;

    // Scheduler FSM state encoding.
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_LAUNCH    = 3'd1;
    localparam logic [2:0] ST_WAIT_ACK  = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE = 3'd3;
    localparam logic [2:0] ST_STORE     = 3'd4;
    localparam logic [2:0] ST_FINISH    = 3'd5;

    // Number of window positions along one axis for a valid (unpadded) convolution.
    function automatic int out_dim(input int img, input int kernel, input int stride);
        return (img - kernel) / stride + 1;
    endfunction

endpackage

// File: rtl/conv_window_scheduler_pos_counter.sv
// Window position counter: tracks the top-left image coordinate of the current
// window and its linear output address, row-major over OUT_H x OUT_W positions.
module conv_pos_counter
    import conv_pkg::*;
#(
    parameter int OUT_H  = 3,
    parameter int OUT_W  = 3,
    parameter int STRIDE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             adv_i,
    output logic [IDX_W-1:0] win_row_o,
    output logic [IDX_W-1:0] win_col_o,
    output logic [IDX_W-1:0] out_idx_o,
    output logic             is_last_o
);

    localparam logic [IDX_W-1:0] ZERO     = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] ONE      = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0] STEP     = IDX_W'(STRIDE);
    localparam logic [IDX_W-1:0] COL_LAST = IDX_W'((OUT_W - 1) * STRIDE);
    localparam logic [IDX_W-1:0] ROW_LAST = IDX_W'((OUT_H - 1) * STRIDE);

    logic [IDX_W-1:0] row_q, row_d;
    logic [IDX_W-1:0] col_q, col_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    // Next position: clear to origin, step along the row with wrap to the next row, or hold.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        idx_d = idx_q;
        if (clr_i) begin
            row_d = ZERO;
            col_d = ZERO;
            idx_d = ZERO;
        end else if (adv_i) begin
            if (col_q == COL_LAST) begin
                col_d = ZERO;
                row_d = row_q + STEP;
            end else begin
                col_d = col_q + STEP;
                row_d = row_q;
            end
            idx_d = idx_q + ONE;
        end else begin
            row_d = row_q;
            col_d = col_q;
            idx_d = idx_q;
        end
    end

    // Position registers; values persist after a frame until the next clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_q <= ZERO;
            col_q <= ZERO;
            idx_q <= ZERO;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
            idx_q <= idx_d;
        end
    end

    assign win_row_o = row_q;
    assign win_col_o = col_q;
    assign out_idx_o = idx_q;
    assign is_last_o = (row_q == ROW_LAST) && (col_q == COL_LAST);

endmodule

// File: rtl/conv_window_scheduler.sv
// Convolution window scheduler: walks every output position of a frame, starts
// the PE on each window, follows its done level, and writes one result per
// position under valid/ready backpressure.
// Optional build macro SCHED_WATCHDOG_EN adds a PE-hang watchdog driving err.
module conv_window_scheduler
    import conv_pkg::*;
#(
    parameter int IMG_H       = 6,
    parameter int IMG_W       = 6,
    parameter int KERNEL_SIZE = 4,
    parameter int STRIDE      = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    input  logic        pe_done,
    output logic        pe_start,
    output logic [31:0] win_row,
    output logic [31:0] win_col,
    output logic [31:0] out_idx,
    output logic        out_we,
    input  logic        out_ready,
    output logic        busy,
    output logic        frame_done,
    output logic        err
);

    localparam int OUT_H = out_dim(IMG_H, KERNEL_SIZE, STRIDE);
    localparam int OUT_W = out_dim(IMG_W, KERNEL_SIZE, STRIDE);

    logic [2:0] state_q, state_d;
    logic       clr_s;
    logic       adv_s;
    logic       is_last_s;
    logic       wd_tmo_s;
    logic       pe_start_q;
    logic       out_we_q;
    logic       busy_q;
    logic       frame_done_q;

    conv_pos_counter #(
        .OUT_H  (OUT_H),
        .OUT_W  (OUT_W),
        .STRIDE (STRIDE)
    ) u_pos (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (clr_s),
        .adv_i     (adv_s),
        .win_row_o (win_row),
        .win_col_o (win_col),
        .out_idx_o (out_idx),
        .is_last_o (is_last_s)
    );

    // Sequencing FSM: launch, wait for PE to drop then raise done, store, repeat.
    always_comb begin
        state_d = state_q;
        clr_s   = 1'b0;
        adv_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (go && pe_done) begin
                    clr_s   = 1'b1;
                    state_d = ST_LAUNCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                state_d = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                // The PE may still show done in the cycle it samples start.
                if (!pe_done) begin
                    state_d = ST_WAIT_DONE;
                end else if (wd_tmo_s) begin
                    state_d = ST_FINISH;
                end else begin
                    state_d = ST_WAIT_ACK;
                end
            end
            ST_WAIT_DONE: begin
                if (pe_done) begin
                    state_d = ST_STORE;
                end else if (wd_tmo_s) begin
                    state_d = ST_FINISH;
                end else begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_STORE: begin
                if (out_ready) begin
                    if (is_last_s) begin
                        state_d = ST_FINISH;
                    end else begin
                        adv_s   = 1'b1;
                        state_d = ST_LAUNCH;
                    end
                end else begin
                    state_d = ST_STORE;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Registered control outputs decoded from the next state, so each is a flop output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pe_start_q   <= 1'b0;
            out_we_q     <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            pe_start_q   <= (state_d == ST_LAUNCH);
            out_we_q     <= (state_d == ST_STORE);
            busy_q       <= (state_d != ST_IDLE);
            frame_done_q <= (state_d == ST_FINISH);
        end
    end

    assign pe_start   = pe_start_q;
    assign out_we     = out_we_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

`ifdef SCHED_WATCHDOG_EN
    // Timeout fires on the last counted cycle so err/frame_done appear K*K+8 cycles after WAIT_ACK entry.
    localparam logic [15:0] WD_LAST = 16'(KERNEL_SIZE * KERNEL_SIZE + 7);

    logic [15:0] wd_q, wd_d;
    logic        err_q, err_d;
    logic        wd_fire_s;

    assign wd_tmo_s  = (wd_q == WD_LAST);
    assign wd_fire_s = wd_tmo_s && (state_d == ST_FINISH) &&
                       ((state_q == ST_WAIT_ACK) || (state_q == ST_WAIT_DONE));

    // Watchdog count: zeroed on the way into WAIT_ACK, counts while waiting on the PE.
    always_comb begin
        wd_d = wd_q;
        if (state_q == ST_LAUNCH) begin
            wd_d = 16'd0;
        end else if ((state_q == ST_WAIT_ACK) || (state_q == ST_WAIT_DONE)) begin
            wd_d = wd_q + 16'd1;
        end else begin
            wd_d = wd_q;
        end
    end

    // Sticky error: set by a watchdog abort, cleared when the next frame is accepted.
    always_comb begin
        err_d = err_q;
        if (clr_s) begin
            err_d = 1'b0;
        end else if (wd_fire_s) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // Watchdog and error registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_q  <= 16'd0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign wd_tmo_s = 1'b0;
    assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_conv_window_scheduler.sv
// Bench for conv_window_scheduler: unit 0 uses the default geometry, unit 1
// uses an 8x8 image with stride 2. Stimulus pushes expected writes into a
// per-unit queue; a negedge monitor pops and compares on every handshake.
module tb_conv_window_scheduler;

    typedef struct {
        int idx;
        int row;
        int col;
        int cyc;
        int hold;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;

    // Cycle counter used as the time base for latency checks.
    always @(posedge clk) cyc <= cyc + 1;

    logic        go_a = 1'b0, go_b = 1'b0;
    logic        done_a, done_b;
    logic        start_a, start_b;
    logic [31:0] row_a, col_a, idx_a, row_b, col_b, idx_b;
    logic        we_a, we_b;
    logic        rdy_a = 1'b1, rdy_b = 1'b1;
    logic        busy_a, busy_b, fd_a, fd_b, err_a, err_b;

    conv_window_scheduler dut_a (
        .clk(clk), .rst(rst), .go(go_a), .pe_done(done_a), .pe_start(start_a),
        .win_row(row_a), .win_col(col_a), .out_idx(idx_a), .out_we(we_a),
        .out_ready(rdy_a), .busy(busy_a), .frame_done(fd_a), .err(err_a)
    );

    conv_window_scheduler #(.IMG_H(8), .IMG_W(8), .KERNEL_SIZE(4), .STRIDE(2)) dut_b (
        .clk(clk), .rst(rst), .go(go_b), .pe_done(done_b), .pe_start(start_b),
        .win_row(row_b), .win_col(col_b), .out_idx(idx_b), .out_we(we_b),
        .out_ready(rdy_b), .busy(busy_b), .frame_done(fd_b), .err(err_b)
    );

    // Behavioural PEs: done drops for 17 cycles after start (200 when hung).
    int   pe_cnt_a = 0, pe_cnt_b = 0;
    logic pe_hold_low_a = 1'b0;
    logic pe_hang_a = 1'b0;
    always @(posedge clk) begin
        if (start_a) pe_cnt_a <= pe_hang_a ? 200 : 17;
        else if (pe_cnt_a != 0) pe_cnt_a <= pe_cnt_a - 1;
        if (start_b) pe_cnt_b <= 17;
        else if (pe_cnt_b != 0) pe_cnt_b <= pe_cnt_b - 1;
    end
    assign done_a = (pe_cnt_a == 0) && !pe_hold_low_a;
    assign done_b = (pe_cnt_b == 0);

    // Hand-computed window origins, row-major.
    int rows_u0[9] = '{0, 0, 0, 1, 1, 1, 2, 2, 2};
    int cols_u0[9] = '{0, 1, 2, 0, 1, 2, 0, 1, 2};
    int rows_u1[9] = '{0, 0, 0, 2, 2, 2, 4, 4, 4};
    int cols_u1[9] = '{0, 2, 4, 0, 2, 4, 0, 2, 4};

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   held[2]        = '{0, 0};
    int   c0[2]          = '{0, 0};
    int   frames[2]      = '{0, 0};
    int   starts[2]      = '{0, 0};
    int   exp_done_c[2]  = '{-1, -1};
    logic exp_err[2]     = '{1'b0, 1'b0};

    function automatic void chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endfunction

    task automatic mon_unit(input int u, input logic st, input logic we, input logic rdy,
                            input logic fd, input logic er, input logic [31:0] idx,
                            input logic [31:0] row, input logic [31:0] col);
        exp_t e;
        int   qs;
        if (st) starts[u]++;
        if (we) held[u]++;
        if (we && rdy) begin
            qs = (u == 0) ? q_a.size() : q_b.size();
            if (qs == 0) begin
                chk($sformatf("u%0d_unexpected_write_idx", u), longint'(idx), -1);
            end else begin
                if (u == 0) e = q_a.pop_front();
                else e = q_b.pop_front();
                chk($sformatf("u%0d_w%0d_out_idx", u, e.idx), longint'(idx), e.idx);
                chk($sformatf("u%0d_w%0d_win_row", u, e.idx), longint'(row), e.row);
                chk($sformatf("u%0d_w%0d_win_col", u, e.idx), longint'(col), e.col);
                chk($sformatf("u%0d_w%0d_hold", u, e.idx), held[u], e.hold);
                if (e.cyc >= 0) chk($sformatf("u%0d_w%0d_cycle", u, e.idx), cyc - c0[u], e.cyc);
            end
            held[u] = 0;
        end
        if (fd) begin
            frames[u]++;
            qs = (u == 0) ? q_a.size() : q_b.size();
            chk($sformatf("u%0d_writes_left_at_done", u), qs, 0);
            chk($sformatf("u%0d_err_at_done", u), longint'(er), longint'(exp_err[u]));
            if (exp_done_c[u] >= 0) chk($sformatf("u%0d_done_cycle", u), cyc - c0[u], exp_done_c[u]);
        end
    endtask

    // Scoreboard monitor: samples both units mid-cycle.
    always @(negedge clk) begin
        mon_unit(0, start_a, we_a, rdy_a, fd_a, err_a, idx_a, row_a, col_a);
        mon_unit(1, start_b, we_b, rdy_b, fd_b, err_b, idx_b, row_b, col_b);
    end

    // Issue go for one cycle and queue the expected writes (stall of len cycles at write stall_at).
    task automatic go_frame(input int u, input int npos, input int stall_at, input int len);
        exp_t e;
        @(posedge clk);
        #1;
        if (u == 0) go_a = 1'b1;
        else go_b = 1'b1;
        c0[u] = cyc;
        for (int k = 0; k < npos; k++) begin
            e.idx  = k;
            e.row  = (u == 0) ? rows_u0[k] : rows_u1[k];
            e.col  = (u == 0) ? cols_u0[k] : cols_u1[k];
            e.cyc  = 20 * (k + 1) + ((k >= stall_at) ? len : 0);
            e.hold = (k == stall_at) ? len + 1 : 1;
            if (u == 0) q_a.push_back(e);
            else q_b.push_back(e);
        end
        @(posedge clk);
        #1;
        go_a = 1'b0;
        go_b = 1'b0;
    endtask

    task automatic wait_frames(input int u, input int target, input int budget);
        int n = 0;
        while (frames[u] < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk($sformatf("u%0d_frames_reached", u), frames[u], target);
        #1;
    endtask

    task automatic wait_pe_idle(input int budget);
        int n = 0;
        while (!done_a && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("pe_idle_reached", longint'(done_a), 1);
        #1;
    endtask

    initial begin
        int f, s;
        #1 rst = 1'b0;
        #1;
        chk("reset_outputs_u0", longint'({start_a, we_a, busy_a, fd_a, err_a, row_a, col_a, idx_a}), 0);
        chk("reset_outputs_u1", longint'({start_b, we_b, busy_b, fd_b, err_b, row_b, col_b, idx_b}), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // 1: default geometry, continuous ready
        exp_done_c[0] = 181;
        s = starts[0];
        go_frame(0, 9, 99, 0);
        wait_frames(0, 1, 400);
        chk("u0_starts_per_frame", starts[0] - s, 9);

        // 2: stride 2 on 8x8
        exp_done_c[1] = 181;
        go_frame(1, 9, 99, 0);
        wait_frames(1, 1, 400);

        // 3: backpressure for 5 cycles at write 3
        exp_done_c[0] = 186;
        go_frame(0, 9, 3, 5);
        repeat (79) @(posedge clk);
        #1;
        chk("stall_entry_we", longint'(we_a), 1);
        chk("stall_entry_idx", longint'(idx_a), 3);
        rdy_a = 1'b0;
        repeat (5) @(posedge clk);
        #1 rdy_a = 1'b1;
        wait_frames(0, 2, 400);

        // 4a: go while PE not idle is dropped
        pe_hold_low_a = 1'b1;
        s = starts[0];
        @(posedge clk);
        #1 go_a = 1'b1;
        repeat (3) @(posedge clk);
        #1 go_a = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("go_pe_busy_no_start", starts[0] - s, 0);
        chk("go_pe_busy_not_busy", longint'(busy_a), 0);
        pe_hold_low_a = 1'b0;

        // 4b: go while busy is ignored
        exp_done_c[0] = 181;
        f = frames[0];
        go_frame(0, 9, 99, 0);
        repeat (49) @(posedge clk);
        #1 go_a = 1'b1;
        @(posedge clk);
        #1 go_a = 1'b0;
        wait_frames(0, f + 1, 400);
        repeat (30) @(posedge clk);
        #1;
        chk("go_busy_frame_count", frames[0], f + 1);
        chk("go_busy_idle_after", longint'(busy_a), 0);

        // 5: reset during WAIT_DONE of position 4, then restart
        exp_done_c[0] = -1;
        go_frame(0, 9, 99, 0);
        repeat (89) @(posedge clk);
        #1;
        chk("pre_reset_busy", longint'(busy_a), 1);
        chk("pre_reset_idx", longint'(idx_a), 4);
        rst = 1'b0;
        #1;
        chk("midframe_reset_outputs", longint'({start_a, we_a, busy_a, fd_a, err_a, row_a, col_a, idx_a}), 0);
        chk("midframe_reset_pending", q_a.size(), 5);
        q_a.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        wait_pe_idle(60);
        exp_done_c[0] = 181;
        f = frames[0];
        go_frame(0, 9, 99, 0);
        wait_frames(0, f + 1, 400);

`ifdef SCHED_WATCHDOG_EN
        // 6: hung PE trips the watchdog
        exp_err[0]    = 1'b1;
        exp_done_c[0] = 26;
        pe_hang_a     = 1'b1;
        f = frames[0];
        go_frame(0, 0, 99, 0);
        wait_frames(0, f + 1, 100);
        chk("wd_err_sticky", longint'(err_a), 1);
        pe_hang_a = 1'b0;
        wait_pe_idle(300);
        exp_err[0]    = 1'b0;
        exp_done_c[0] = 181;
        go_frame(0, 9, 99, 0);
        chk("wd_err_cleared_by_go", longint'(err_a), 0);
        wait_frames(0, f + 2, 400);
`endif

        repeat (5) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #100000;
        n_err++;
        $display("FAIL global_timeout: got time %0t expected finish earlier", $time);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $fatal(1, "timeout");
    end

endmodule
